// File: rtl/ctrl_regs_pkg.sv
// Shared constants for the control register bank and the DSI/HDMI blocks that consume it.
// Also holds the byte-strobe merge helper used on register commit.
package ctrl_regs_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    // Register slots as wired into the datapath blocks.
    localparam int unsigned CTRL_REG_DSI_CTRL    = 0;
    localparam int unsigned CTRL_REG_DSI_TIMING  = 1;
    localparam int unsigned CTRL_REG_DSI_LANES   = 2;
    localparam int unsigned CTRL_REG_DSI_IRQ     = 3;
    localparam int unsigned CTRL_REG_HDMI_CTRL   = 4;
    localparam int unsigned CTRL_REG_HDMI_TIMING = 5;
    localparam int unsigned CTRL_REG_HDMI_INFO   = 6;
    localparam int unsigned CTRL_REG_HDMI_IRQ    = 7;

    function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
        input logic [AXI_DATA_W-1:0] old_val,
        input logic [AXI_DATA_W-1:0] new_val,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] res;
        res = old_val;
        for (int k = 0; k < int'(AXI_STRB_W); k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ctrl_reg_decode.sv
// Combinational address decode for the register window: RW slot, RO status slot or unmapped.
// Byte offset bits [1:0] take no part in the decode.
module ctrl_reg_decode
    import ctrl_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned NUM_STATUS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic [31:0]           i_addr,
    output logic                  o_is_rw,
    output logic                  o_is_ro,
    output logic [ADDR_WIDTH-3:0] o_idx
);

    logic        w_in_win;
    logic [31:0] w_idx32;
    logic        w_unused_byte_ofs;

    assign w_in_win          = (i_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign o_idx             = i_addr[ADDR_WIDTH-1:2];
    assign w_idx32           = 32'(i_addr[ADDR_WIDTH-1:2]);
    assign w_unused_byte_ofs = ^i_addr[1:0];

    assign o_is_rw = w_in_win && (w_idx32 < NUM_REGS);
    assign o_is_ro = w_in_win && (w_idx32 >= NUM_REGS) && (w_idx32 < NUM_REGS + NUM_STATUS);

endmodule

// File: rtl/axi_ctrl_regfile.sv
// AXI4 single-beat slave holding RW control registers and RO status words.
// Independent one-entry AW and W buffers feed a commit stage gated by the B channel.
module axi_ctrl_regfile
    import ctrl_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned NUM_STATUS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RST_VAL    = 32'h0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [AXI_ID_W-1:0]                s_axi_awid,
    input  logic [31:0]                        s_axi_awaddr,
    input  logic [7:0]                         s_axi_awlen,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_DATA_W-1:0]              s_axi_wdata,
    input  logic [AXI_STRB_W-1:0]              s_axi_wstrb,
    input  logic                               s_axi_wlast,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [AXI_ID_W-1:0]                s_axi_bid,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [AXI_ID_W-1:0]                s_axi_arid,
    input  logic [31:0]                        s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [AXI_ID_W-1:0]                s_axi_rid,
    output logic [AXI_DATA_W-1:0]              s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rlast,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [NUM_REGS*AXI_DATA_W-1:0]     reg_out,
    output logic [NUM_REGS-1:0]                reg_wr_pulse,
    input  logic [NUM_STATUS*AXI_DATA_W-1:0]   status_in
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;

    logic                                r_rdy;
    logic                                r_aw_full;
    logic [AXI_ID_W-1:0]                 r_awid;
    logic [IDX_W-1:0]                    r_aw_idx;
    logic                                r_aw_ok;
    logic                                r_w_full;
    logic [AXI_DATA_W-1:0]               r_wdata;
    logic [AXI_STRB_W-1:0]               r_wstrb;
    logic                                r_bvalid;
    logic [AXI_ID_W-1:0]                 r_bid;
    logic [1:0]                          r_bresp;
    logic [NUM_REGS-1:0][AXI_DATA_W-1:0] r_regs;
    logic [NUM_REGS-1:0]                 r_wr_pulse;
    logic                                r_rvalid;
    logic [AXI_ID_W-1:0]                 r_rid;
    logic [AXI_DATA_W-1:0]               r_rdata;
    logic [1:0]                          r_rresp;

    logic                  w_aw_is_rw;
    logic                  w_unused_aw_is_ro;
    logic [IDX_W-1:0]      w_aw_idx;
    logic                  w_ar_is_rw;
    logic                  w_ar_is_ro;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [AXI_DATA_W-1:0] w_rd_data;

    ctrl_reg_decode #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STATUS (NUM_STATUS),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_aw_dec (
        .i_addr  (s_axi_awaddr),
        .o_is_rw (w_aw_is_rw),
        .o_is_ro (w_unused_aw_is_ro),
        .o_idx   (w_aw_idx)
    );

    ctrl_reg_decode #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STATUS (NUM_STATUS),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ar_dec (
        .i_addr  (s_axi_araddr),
        .o_is_rw (w_ar_is_rw),
        .o_is_ro (w_ar_is_ro),
        .o_idx   (w_ar_idx)
    );

    // r_rdy keeps every ready low while reset is asserted and for the release edge.
    assign s_axi_awready = r_rdy && !r_aw_full;
    assign s_axi_wready  = r_rdy && !r_w_full;
    assign s_axi_arready = r_rdy && (!r_rvalid || s_axi_rready);

    assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
    assign w_commit = r_aw_full && r_w_full && (!r_bvalid || s_axi_bready);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_ar_is_rw && (w_ar_idx == IDX_W'(i))) w_rd_data = r_regs[i];
        end
        for (int j = 0; j < int'(NUM_STATUS); j++) begin
            if (w_ar_is_ro && (w_ar_idx == IDX_W'(NUM_REGS + j))) begin
                w_rd_data = status_in[j*AXI_DATA_W +: AXI_DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 1'b0;
            r_aw_full <= 1'b0;
            r_awid    <= '0;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awid    <= s_axi_awid;
                r_aw_idx  <= w_aw_idx;
                r_aw_ok   <= w_aw_is_rw && (s_axi_awlen == 8'd0);
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end
            // Non-last beats are acknowledged but never stored.
            if (w_w_hs && s_axi_wlast) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= AXI_RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= RST_VAL;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bid    <= r_awid;
                r_bresp  <= r_aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (r_aw_ok && (r_aw_idx == IDX_W'(i))) begin
                        r_regs[i]     <= apply_wstrb(r_regs[i], r_wdata, r_wstrb);
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
            end else if (s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= AXI_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rid    <= s_axi_arid;
            r_rdata  <= w_rd_data;
            r_rresp  <= (w_ar_is_rw || w_ar_is_ro) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end else if (s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bid    = r_bid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rid    = r_rid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rlast  = 1'b1;
    assign reg_out      = r_regs;
    assign reg_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi_ctrl_regfile.sv
// Directed and randomized checks of axi_ctrl_regfile against a register-array reference model.
module tb_axi_ctrl_regfile;

    localparam int NR = 8;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    s_axi_awid = '0;
    logic [31:0]   s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [3:0]    s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b1;
    logic [3:0]    s_axi_arid = '0;
    logic [31:0]   s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [3:0]    s_axi_rid;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b1;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]    reg_wr_pulse;
    logic [NS*32-1:0] status_in = '0;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] m_regs [NR];
    logic [31:0] m_stat [NS];

    axi_ctrl_regfile #(
        .NUM_REGS   (NR),
        .NUM_STATUS (NS),
        .BASE_ADDR  (32'h0000_1000),
        .ADDR_WIDTH (10),
        .RST_VAL    (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse),
        .status_in     (status_in)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_status();
        for (int i = 0; i < NS; i++) status_in[32*i +: 32] = m_stat[i];
    endtask

    // 0 = RW register, 1 = RO status word, 2 = unmapped
    function automatic int kind_of(input logic [31:0] a);
        int idx;
        idx = int'((a % 1024) / 4);
        if ((a / 1024) != (32'h1000 / 1024)) return 2;
        if (idx < NR) return 0;
        if (idx < NR + NS) return 1;
        return 2;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
        int beats;
        int wsent;
        int cyc;
        bit aw_done;
        bit af;
        bit wf;
        beats = int'(len) + 1;
        wsent = 0;
        cyc = 0;
        aw_done = 0;
        s_axi_awaddr = addr;
        s_axi_awid = id;
        s_axi_awlen = len;
        s_axi_wstrb = strb;
        while ((!aw_done || wsent < beats) && cyc < 200) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid = (wsent < beats) && (cyc >= w_dly);
            s_axi_wlast = (wsent == beats - 1);
            s_axi_wdata = (wsent == beats - 1) ? data : $urandom;
            af = s_axi_awvalid && s_axi_awready;
            wf = s_axi_wvalid && s_axi_wready;
            tick();
            cyc++;
            if (af) aw_done = 1;
            if (wf) wsent++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
        chk("write_handshakes_done", {aw_done, wsent == beats}, 2'b11);
    endtask

    // Full write: model update, B response, pulse timing and latency checks.
    task automatic chk_write(input string tag, input logic [31:0] addr, input logic [3:0] id,
                             input logic [7:0] len, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        int k;
        int idx;
        int lat;
        logic [1:0] exp_resp;
        logic [NR-1:0] exp_pulse;
        bit seen;
        k = kind_of(addr);
        idx = int'((addr % 1024) / 4);
        exp_pulse = '0;
        exp_resp = 2'b10;
        if (k == 0 && len == 0) begin
            exp_resp = 2'b00;
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        do_write(addr, id, len, data, strb, aw_dly, w_dly);
        seen = 0;
        lat = 0;
        while (!seen && lat < 20) begin
            if (s_axi_bvalid) seen = 1;
            else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_b_latency"}, 64'(lat), 64'd1);
        chk({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(s_axi_bid), 64'(id));
        chk({tag, "_pulse"}, 64'(reg_wr_pulse), 64'(exp_pulse));
        tick();
        chk({tag, "_pulse_end"}, 64'(reg_wr_pulse), 64'd0);
        chk({tag, "_b_retired"}, 64'(s_axi_bvalid), 64'd0);
    endtask

    task automatic chk_read(input string tag, input logic [31:0] addr, input logic [3:0] id);
        int k;
        int idx;
        int cyc;
        bit fired;
        bit f;
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        k = kind_of(addr);
        idx = int'((addr % 1024) / 4);
        exp_data = '0;
        exp_resp = 2'b10;
        if (k == 0) begin
            exp_data = m_regs[idx];
            exp_resp = 2'b00;
        end else if (k == 1) begin
            exp_data = m_stat[idx - NR];
            exp_resp = 2'b00;
        end
        s_axi_araddr = addr;
        s_axi_arid = id;
        s_axi_arvalid = 1'b1;
        fired = 0;
        cyc = 0;
        while (!fired && cyc < 20) begin
            f = s_axi_arready;
            tick();
            cyc++;
            if (f) fired = 1;
        end
        s_axi_arvalid = 1'b0;
        chk({tag, "_r_valid"}, 64'({fired, s_axi_rvalid}), 64'd3);
        chk({tag, "_rdata"}, 64'(s_axi_rdata), 64'(exp_data));
        chk({tag, "_rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
        chk({tag, "_rid"}, 64'(s_axi_rid), 64'(id));
        tick();
    endtask

    initial begin
        int bcount;
        logic [31:0] a;
        logic [7:0] len;
        bit wf;

        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < NS; i++) m_stat[i] = $urandom;
        m_stat[0] = 32'hCAFE_0001;
        push_status();

        // Reset state
        #12;
        chk("rst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        chk("rst_valids", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
        chk("rst_reg_out", 64'(reg_out[63:0]), 64'd0);
        chk("rst_pulse", 64'(reg_wr_pulse), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);

        chk_read("rd_reg0_rst", 32'h1000, 4'h1);
        chk_read("rd_reg1_rst", 32'h1004, 4'h2);

        chk_write("wr_reg1", 32'h1004, 4'h3, 8'd0, 32'hA5A5_1234, 4'hF, 0, 0);
        chk("reg1_value", 64'(reg_out[63:32]), 64'hA5A5_1234);

        // W two cycles ahead of AW, single-byte strobe
        chk_write("wr_reg2_full", 32'h1008, 4'h4, 8'd0, 32'h1122_3344, 4'hF, 0, 0);
        chk_write("wr_reg2_byte", 32'h1008, 4'h5, 8'd0, 32'hFFFF_FFFF, 4'b0010, 2, 0);
        chk("reg2_value", 64'(reg_out[95:64]), 64'h1122_FF44);
        chk_read("rd_reg2", 32'h100A, 4'h6);

        chk_read("rd_status0", 32'h1020, 4'h7);
        chk_write("wr_status0", 32'h1020, 4'h8, 8'd0, 32'hDEAD_BEEF, 4'hF, 0, 0);
        chk_read("rd_status0_again", 32'h1020, 4'h9);

        chk_read("rd_out_of_window", 32'h2000, 4'hA);
        chk_write("wr_burst", 32'h1030, 4'hB, 8'd2, 32'h5555_AAAA, 4'hF, 0, 0);
        bcount = 0;
        for (int c = 0; c < 4; c++) begin
            if (s_axi_bvalid) bcount++;
            tick();
        end
        chk("burst_single_b", 64'(bcount), 64'd0);

        // B backpressure: second transaction parks in the buffers
        s_axi_bready = 1'b0;
        for (int b = 0; b < 4; b++) m_regs[3][8*b +: 8] = 8'h30 + 8'(b);
        for (int b = 0; b < 4; b++) m_regs[4][8*b +: 8] = 8'h40 + 8'(b);
        do_write(32'h100C, 4'h5, 8'd0, 32'h3332_3130, 4'hF, 0, 0);
        do_write(32'h1010, 4'h6, 8'd0, 32'h4342_4140, 4'hF, 0, 0);
        chk("bp_buffers_full", 64'({s_axi_awready, s_axi_wready}), 64'd0);
        bcount = 0;
        for (int c = 0; c < 5; c++) begin
            if (s_axi_bvalid && s_axi_bid == 4'h5) bcount++;
            tick();
        end
        chk("bp_first_b_held", 64'(bcount), 64'd5);
        chk("bp_reg4_not_yet", 64'(reg_out[159:128]), 64'd0);
        s_axi_bready = 1'b1;
        tick();
        chk("bp_second_b", 64'({s_axi_bvalid, s_axi_bid, s_axi_bresp}), 64'({1'b1, 4'h6, 2'b00}));
        chk("bp_reg4_pulse", 64'(reg_wr_pulse), 64'h10);
        tick();
        chk("bp_b_drained", 64'(s_axi_bvalid), 64'd0);

        // Randomized mix of reads and writes against the model
        for (int n = 0; n < 60; n++) begin
            a = 32'h1000 + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
            if ($urandom_range(7) == 0) begin
                a = $urandom;
                if ((a / 1024) == 4) a = a ^ 32'h0010_0000;
            end
            if ($urandom_range(1) == 0) begin
                len = ($urandom_range(5) == 0) ? 8'($urandom_range(3, 1)) : 8'd0;
                chk_write("rnd_wr", a, 4'($urandom), len, $urandom, 4'($urandom),
                          $urandom_range(2), $urandom_range(2));
            end else begin
                for (int i = 0; i < NS; i++) m_stat[i] = $urandom;
                push_status();
                chk_read("rnd_rd", a, 4'($urandom));
            end
        end

        for (int i = 0; i < NR; i++) chk("final_reg", 64'(reg_out[32*i +: 32]), 64'(m_regs[i]));

        // Reset between AW handshake and commit drops the write
        s_axi_awaddr = 32'h1014;
        s_axi_awid = 4'hC;
        s_axi_awlen = 8'd0;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_readies_low", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("midrst_readies_back", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);
        s_axi_wdata = 32'h7777_7777;
        s_axi_wstrb = 4'hF;
        s_axi_wlast = 1'b1;
        s_axi_wvalid = 1'b1;
        wf = s_axi_wready;
        tick();
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
        chk("midrst_w_accepted", 64'(wf), 64'd1);
        bcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (s_axi_bvalid || reg_wr_pulse != '0) bcount++;
            tick();
        end
        chk("midrst_no_b", 64'(bcount), 64'd0);
        chk("midrst_reg5", 64'(reg_out[191:160]), 64'(m_regs[5]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ctrl_regfile.md
Name: axi_ctrl_regfile

Overview:
AXI4 single-beat slave register bank sitting directly downstream of the core-to-AXI bridge, consuming its AW/W/B/AR/R master channels. It holds NUM_REGS read/write 32-bit control registers and exposes NUM_STATUS read-only status words to the processor core. Every register value is driven in parallel to the DSI/HDMI datapath blocks, with a per-register write strobe.

Parameters:
NUM_REGS, 8, number of RW control registers (1..64)
NUM_STATUS, 4, number of RO status words (0..64)
BASE_ADDR, 32'h0000_1000, window base; low ADDR_WIDTH bits are zero
ADDR_WIDTH, 10, byte-address window size in bits
RST_VAL, 32'h0, reset value of every RW register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axi_awid  in  4  write ID
s_axi_awaddr  in  32  write byte address
s_axi_awlen  in  8  burst length-1; only 0 is supported
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wlast  in  1  last beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  4  captured awid
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  4  read ID
s_axi_araddr  in  32  read byte address
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  4  captured arid
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  tied 1
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
reg_out  out  NUM_REGS*32  flattened RW register contents, reg i at [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle strobe on commit to reg i
status_in  in  NUM_STATUS*32  flattened RO status words

Behaviour:
- Reset (async, rst_n low): awready=wready=arready=0 during reset, 1 after; bvalid=rvalid=0; bid/rid/bresp/rresp/rdata=0; reg_out=RST_VAL per reg; reg_wr_pulse=0; AW/W buffers empty. Reset mid-transaction drops the transaction silently.
- Decode: in-window when addr[31:ADDR_WIDTH]==BASE_ADDR[31:ADDR_WIDTH]; idx=addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. idx<NUM_REGS selects RW; NUM_REGS<=idx<NUM_REGS+NUM_STATUS selects RO; anything else is unmapped.
- Write path: one-entry AW buffer and one-entry W buffer, independent. awready=!aw_full; wready=!w_full || !wlast_seen. W beats with wlast=0 are accepted and discarded. W is complete only on the beat with wlast=1, whose data/strb is held.
- Commit: at the edge where aw_full && w_complete && (!bvalid || bready). Both buffers clear. bvalid=1, bid=awid after that edge. Minimum latency: AW+W handshake at edge T gives commit at T+1, with bvalid visible after T+1.
- Commit effect for RW idx with awlen==0: byte k is updated where wstrb[k]=1; reg_wr_pulse[idx]=1 for exactly the cycle after commit; bresp=OKAY. For RO, unmapped, or awlen!=0: no register change, no pulse, bresp=SLVERR.
- bvalid holds until bready; a new commit may occur in the same cycle bready retires the old B.
- Read path: arready=!rvalid || rready. On AR handshake at edge T, the following are registered at T: rvalid=1, rid=arid, rdata=reg/status word, rresp=OKAY. Latency is 1 cycle.
- Unmapped reads return rdata=0 and rresp=SLVERR.
- rvalid holds until rready; back-to-back reads are accepted at one per cycle when rready=1.
- Read and write are independent. A read and a commit to the same register at the same edge returns the pre-commit value.
- status_in is sampled at the AR handshake edge, with no extra synchronisation; it is the caller's clock domain.

Decomposition:
- Shared package ctrl_regs_pkg: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_ID_W=4, AXI_DATA_W=32, and the register index constants used by datapath blocks.
- One sub-module, ctrl_reg_decode: combinational addr -> {is_rw, is_ro, idx}. It is instantiated twice, for AW and AR.

Test Plan:
- Reset: both registers read back 0, OKAY. Drive AW(0x1004, id 3) and W(0xA5A5_1234, strb F, last) in the same cycle -> bvalid 2 cycles later, bid=3, OKAY; reg_out[63:32]=A5A51234; reg_wr_pulse[1] high for 1 cycle.
- Write W two cycles before AW, then write with strb 4'b0010 and data 0xFFFF_FFFF to a register holding 0x1122_3344 -> final value 0x1122_FF44; bresp OKAY.
- Read 0x1020 with status_in word0=0xCAFE_0001 (NUM_REGS=8) -> rvalid 1 cycle after AR, rdata CAFE0001, OKAY. Write to 0x1020 -> SLVERR, status unchanged.
- Read 0x2000 (out of window) -> rdata 0, SLVERR. Write 0x1030 with awlen=2 and 3 W beats -> all beats accepted, one B SLVERR, no pulse.
- Hold bready=0 for 5 cycles after first B; issue second AW+W -> awready/wready drop once buffers full; second commit only when bready=1; B order and IDs preserved.
- Assert rst_n low between AW handshake and commit -> no B ever issued, register unchanged, interface ready after release.
